// File: rtl/fb_sram_arbiter_pkg.sv
// Shared definitions for the framebuffer SRAM arbiter: FSM encoding, SRAM
// bus widths and default parameter values.
package fb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VGA    = 2'd1,
    ST_ACCESS = 2'd2
  } arb_state_e;

  localparam int unsigned SRAM_DQ_W   = 16;
  localparam int unsigned SRAM_ADDR_W = 18;

  localparam int unsigned DEF_NUM_CLIENTS   = 2;
  localparam int unsigned DEF_ADDR_WIDTH    = 18;
  localparam int unsigned DEF_DATA_WIDTH    = 16;
  localparam int unsigned DEF_ACCESS_CYCLES = 2;

  // Width needed to hold values 0..n-1, never less than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fb_sram_arbiter_rr_arbiter.sv
// Combinational client picker: request vector + pointer -> one-hot grant and
// index of the winner. Define FB_ARB_FIXED_PRIO_EN for lowest-index-wins
// priority (pointer ignored); otherwise round-robin starting at the pointer.
module rr_arbiter
  import fb_arb_pkg::*;
#(
  parameter  int unsigned NUM_CLIENTS = DEF_NUM_CLIENTS,
  localparam int unsigned IDX_W       = idx_width(NUM_CLIENTS)
) (
  input  logic [NUM_CLIENTS-1:0] req,
  input  logic [IDX_W-1:0]       ptr,
  output logic [NUM_CLIENTS-1:0] grant,
  output logic [IDX_W-1:0]       idx,
  output logic                   valid
);

  int unsigned cand;

`ifdef FB_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;
`endif

  // Scan candidates in priority order and take the first requester.
  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = 0;
    for (int unsigned k = 0; k < NUM_CLIENTS; k++) begin
`ifdef FB_ARB_FIXED_PRIO_EN
      cand = k;
`else
      cand = (32'(ptr) + k) % NUM_CLIENTS;
`endif
      if (!valid && req[cand]) begin
        valid       = 1'b1;
        grant[cand] = 1'b1;
        idx         = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/fb_sram_arbiter.sv
// Framebuffer SRAM arbiter: VGA scan-out has absolute priority, GPU clients
// share the remaining bandwidth through a request/done handshake. A client
// access interrupted by scan-out is dropped and re-arbitrated later.
// Optional macro FB_ARB_FIXED_PRIO_EN selects fixed lowest-index priority.
module fb_sram_arbiter
  import fb_arb_pkg::*;
#(
  parameter int unsigned NUM_CLIENTS   = DEF_NUM_CLIENTS,
  parameter int unsigned ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int unsigned ACCESS_CYCLES = DEF_ACCESS_CYCLES
) (
  input  logic                              I_CLK,
  input  logic                              I_RST,
  input  logic                              I_VGA_READ,
  input  logic [ADDR_WIDTH-1:0]             I_VGA_ADDR,
  output logic [DATA_WIDTH-1:0]             O_VGA_DATA,
  input  logic [NUM_CLIENTS-1:0]            I_REQ,
  input  logic [NUM_CLIENTS-1:0]            I_WE,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] I_ADDR,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] I_WDATA,
  output logic [NUM_CLIENTS-1:0]            O_DONE,
  output logic [DATA_WIDTH-1:0]             O_RDATA,
  inout  wire  [SRAM_DQ_W-1:0]              IO_SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0]            O_SRAM_ADDR,
  output logic                              O_SRAM_UB_N,
  output logic                              O_SRAM_LB_N,
  output logic                              O_SRAM_CE_N,
  output logic                              O_SRAM_OE_N,
  output logic                              O_SRAM_WE_N
);

  localparam int unsigned IDX_W = idx_width(NUM_CLIENTS);
  localparam int unsigned CNT_W = idx_width(ACCESS_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

  arb_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_CLIENTS-1:0] gnt_q, gnt_d;
  logic                   we_q, we_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0]  vga_data_q, vga_data_d;

  logic [NUM_CLIENTS-1:0] arb_gnt;
  logic [IDX_W-1:0]       arb_idx;
  logic                   arb_valid;

  logic [SRAM_DQ_W-1:0]   dq_in;
  logic                   dq_oe;
  logic [SRAM_ADDR_W-1:0] sram_addr;
  logic                   oe_n, we_n;
  logic [NUM_CLIENTS-1:0] done;
  logic [DATA_WIDTH-1:0]  rdata_out;

  rr_arbiter #(
    .NUM_CLIENTS(NUM_CLIENTS)
  ) u_rr_arbiter (
    .req  (I_REQ),
    .ptr  (ptr_q),
    .grant(arb_gnt),
    .idx  (arb_idx),
    .valid(arb_valid)
  );

  assign dq_in      = IO_SRAM_DQ;
  assign IO_SRAM_DQ = dq_oe ? SRAM_DQ_W'(wdata_q) : {SRAM_DQ_W{1'bz}};

  assign O_SRAM_ADDR = sram_addr;
  assign O_SRAM_OE_N = oe_n;
  assign O_SRAM_WE_N = we_n;
  assign O_SRAM_CE_N = 1'b0;
  assign O_SRAM_UB_N = 1'b0;
  assign O_SRAM_LB_N = 1'b0;
  assign O_VGA_DATA  = vga_data_q;
  assign O_DONE      = done;
  assign O_RDATA     = rdata_out;

  // State and latched-transaction registers; reset forces WE_N high at once
  // because the SRAM strobes are decoded from state_q.
  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      ptr_q      <= '0;
      idx_q      <= '0;
      gnt_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      vga_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      idx_q      <= idx_d;
      gnt_q      <= gnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      vga_data_q <= vga_data_d;
    end
  end

  // Next-state and SRAM bus decode; DONE is raised during the last access
  // cycle so a client can drop REQ before the arbiter is back in IDLE.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    idx_d      = idx_q;
    gnt_d      = gnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    vga_data_d = vga_data_q;
    sram_addr  = '0;
    oe_n       = 1'b1;
    we_n       = 1'b1;
    dq_oe      = 1'b0;
    done       = '0;
    rdata_out  = rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (I_VGA_READ) begin
          state_d = ST_VGA;
        end else if (arb_valid) begin
          idx_d   = arb_idx;
          gnt_d   = arb_gnt;
          we_d    = I_WE[arb_idx];
          addr_d  = I_ADDR[32'(arb_idx)*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d = I_WDATA[32'(arb_idx)*DATA_WIDTH +: DATA_WIDTH];
          cnt_d   = '0;
          state_d = ST_ACCESS;
        end
      end

      ST_VGA: begin
        sram_addr  = SRAM_ADDR_W'(I_VGA_ADDR);
        oe_n       = 1'b0;
        vga_data_d = DATA_WIDTH'(dq_in);
        if (!I_VGA_READ) state_d = ST_IDLE;
      end

      ST_ACCESS: begin
        sram_addr = SRAM_ADDR_W'(addr_q);
        if (we_q) begin
          dq_oe = 1'b1;
          we_n  = (cnt_q == CNT_LAST);
        end else begin
          oe_n = 1'b0;
        end
        if (I_VGA_READ) begin
          state_d = ST_VGA;
        end else if (cnt_q == CNT_LAST) begin
          done = gnt_q;
          if (!we_q) begin
            rdata_d   = DATA_WIDTH'(dq_in);
            rdata_out = DATA_WIDTH'(dq_in);
          end
`ifdef FB_ARB_FIXED_PRIO_EN
          ptr_d = '0;
`else
          ptr_d = (idx_q == IDX_W'(NUM_CLIENTS - 1)) ? '0 : idx_q + 1'b1;
`endif
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule
